// File: rtl/hier_skid_pipeline.sv
// Multi-lane valid/ready pipeline built from a generated chain of register slices.
// Each lane is an independent, flushable FIFO path with per-stage backpressure.

module hier_skid_slice #(
    parameter int WIDTH = 3,
    parameter int MODE  = 0
) (
    input  logic             i_clk,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_sData,
    input  logic             i_sValid,
    output logic             o_sReady,
    output logic [WIDTH-1:0] o_mData,
    output logic             o_mValid,
    input  logic             i_mReady
);

    if (MODE == 0) begin : g_skid
        logic [WIDTH-1:0] r_main;
        logic [WIDTH-1:0] r_skid;
        logic             r_mainValid;
        logic             r_skidValid;
        logic             w_mainFree;

        assign w_mainFree = !r_mainValid || i_mReady;

        // A parked skid word always moves to main before any new input is taken.
        always_ff @(posedge i_clk) begin
            if (i_clear) begin
                r_mainValid <= 1'b0;
                r_skidValid <= 1'b0;
            end else if (r_skidValid) begin
                if (w_mainFree) begin
                    r_main      <= r_skid;
                    r_mainValid <= 1'b1;
                    r_skidValid <= 1'b0;
                end
            end else if (i_sValid) begin
                if (w_mainFree) begin
                    r_main      <= i_sData;
                    r_mainValid <= 1'b1;
                end else begin
                    r_skid      <= i_sData;
                    r_skidValid <= 1'b1;
                end
            end else if (i_mReady) begin
                r_mainValid <= 1'b0;
            end
        end

        assign o_sReady = !r_skidValid;
        assign o_mData  = r_main;
        assign o_mValid = r_mainValid;
    end else begin : g_half
        logic [WIDTH-1:0] r_main;
        logic             r_mainValid;

        always_ff @(posedge i_clk) begin
            if (i_clear) begin
                r_mainValid <= 1'b0;
            end else if (r_mainValid) begin
                if (i_mReady) begin
                    r_mainValid <= 1'b0;
                end
            end else if (i_sValid) begin
                r_main      <= i_sData;
                r_mainValid <= 1'b1;
            end
        end

        assign o_sReady = !r_mainValid;
        assign o_mData  = r_main;
        assign o_mValid = r_mainValid;
    end

endmodule

module hier_skid_pipeline #(
    parameter int WIDTH    = 3,
    parameter int CHANNELS = 2,
    parameter int STAGES   = 2,
    parameter int MODE     = 0,
    localparam int OW      = (STAGES == 0) ? 1 : $clog2(2*STAGES+1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]      in_valid,
    output logic [CHANNELS-1:0]      in_ready,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic [CHANNELS-1:0]      out_valid,
    input  logic [CHANNELS-1:0]      out_ready,
    output logic [CHANNELS*OW-1:0]   occupancy
);

    logic w_block;

    assign w_block = rst || flush;

    for (genvar c = 0; c < CHANNELS; c++) begin : lane
        if (STAGES == 0) begin : g_pass
            assign out_data[c*WIDTH +: WIDTH] = in_data[c*WIDTH +: WIDTH];
            assign out_valid[c]               = in_valid[c] && !w_block;
            assign in_ready[c]                = out_ready[c] && !w_block;
            assign occupancy[c*OW +: OW]      = '0;
        end else begin : g_chain
            logic [WIDTH-1:0] w_data [STAGES+1];
            logic [STAGES:0]  w_valid;
            logic [STAGES:0]  w_ready;
            logic [OW-1:0]    r_occ;
            logic             w_inXfer;
            logic             w_outXfer;

            assign w_data[0]       = in_data[c*WIDTH +: WIDTH];
            assign w_valid[0]      = in_valid[c];
            assign w_ready[STAGES] = out_ready[c];

            for (genvar s = 0; s < STAGES; s++) begin : stage
                hier_skid_slice #(
                    .WIDTH (WIDTH),
                    .MODE  (MODE)
                ) u_slice (
                    .i_clk    (clk),
                    .i_clear  (w_block),
                    .i_sData  (w_data[s]),
                    .i_sValid (w_valid[s]),
                    .o_sReady (w_ready[s]),
                    .o_mData  (w_data[s+1]),
                    .o_mValid (w_valid[s+1]),
                    .i_mReady (w_ready[s+1])
                );
            end

            // Handshakes are gated at the lane boundary only; the clear wipes the interior anyway.
            assign in_ready[c]                = w_ready[0] && !w_block;
            assign out_valid[c]               = w_valid[STAGES] && !w_block;
            assign out_data[c*WIDTH +: WIDTH] = w_data[STAGES];

            assign w_inXfer  = in_valid[c] && in_ready[c];
            assign w_outXfer = out_valid[c] && out_ready[c];

            always_ff @(posedge clk) begin
                if (w_block) begin
                    r_occ <= '0;
                end else if (w_inXfer && !w_outXfer) begin
                    r_occ <= r_occ + OW'(1);
                end else if (!w_inXfer && w_outXfer) begin
                    r_occ <= r_occ - OW'(1);
                end
            end

            assign occupancy[c*OW +: OW] = rst ? '0 : r_occ;
        end
    end

endmodule

// File: tb/tb_hier_skid_pipeline.sv
// Self-checking bench: three pipeline configurations against a FIFO scoreboard
// plus directed scenarios with hand-computed expectations.

module tb_hier_skid_pipeline;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;

    always #5 clk = ~clk;

    // Bench lanes 0,1 = default DUT lanes; lane 2 = MODE 1 / STAGES 3 DUT.
    logic [2:0] inValid = '0;
    logic [2:0] outReady = '0;
    logic [2:0] inData [3];
    logic [2:0] inReady;
    logic [2:0] outValid;
    logic [2:0] outData [3];
    logic [2:0] occ [3];

    logic [5:0] d0OutData;
    logic [1:0] d0InReady, d0OutValid;
    logic [5:0] d0Occ;
    logic [2:0] d1OutData;
    logic       d1InReady, d1OutValid;
    logic [2:0] d1Occ;

    logic [5:0] d2InData = '0;
    logic [1:0] d2InValid = '0;
    logic [1:0] d2OutReady = '0;
    logic [5:0] d2OutData;
    logic [1:0] d2InReady, d2OutValid;
    logic [1:0] d2Occ;

    hier_skid_pipeline #(.WIDTH(3), .CHANNELS(2), .STAGES(2), .MODE(0)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_data({inData[1], inData[0]}), .in_valid(inValid[1:0]), .in_ready(d0InReady),
        .out_data(d0OutData), .out_valid(d0OutValid), .out_ready(outReady[1:0]),
        .occupancy(d0Occ)
    );

    hier_skid_pipeline #(.WIDTH(3), .CHANNELS(1), .STAGES(3), .MODE(1)) dutHalf (
        .clk(clk), .rst(rst), .flush(flush),
        .in_data(inData[2]), .in_valid(inValid[2]), .in_ready(d1InReady),
        .out_data(d1OutData), .out_valid(d1OutValid), .out_ready(outReady[2]),
        .occupancy(d1Occ)
    );

    hier_skid_pipeline #(.WIDTH(3), .CHANNELS(2), .STAGES(0), .MODE(0)) dutPass (
        .clk(clk), .rst(rst), .flush(flush),
        .in_data(d2InData), .in_valid(d2InValid), .in_ready(d2InReady),
        .out_data(d2OutData), .out_valid(d2OutValid), .out_ready(d2OutReady),
        .occupancy(d2Occ)
    );

    assign inReady    = {d1InReady, d0InReady};
    assign outValid   = {d1OutValid, d0OutValid};
    assign outData[0] = d0OutData[2:0];
    assign outData[1] = d0OutData[5:3];
    assign outData[2] = d1OutData;
    assign occ[0]     = d0Occ[2:0];
    assign occ[1]     = d0Occ[5:3];
    assign occ[2]     = d1Occ;

    int nVectors = 0;
    int nErrors  = 0;
    int cyc      = 0;

    logic [2:0] toSend [3][$];
    logic [2:0] got    [3][$];
    int         gotCyc [3][$];
    int         accCyc [3][$];
    int         maxOcc [3];

    // Scoreboard state: words each lane must still hold, in order.
    logic [2:0] mq [3][$];
    int         cap [3] = '{4, 4, 3};
    bit         stalled [3] = '{0, 0, 0};
    logic [2:0] heldData [3];

    task automatic checkOutput(input string name, input int actual, input int expected);
        nVectors++;
        if (actual !== expected) begin
            nErrors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic int gotAt(input int l, input int i);
        return (i < got[l].size()) ? int'(got[l][i]) : -1;
    endfunction

    function automatic int gotCycAt(input int l, input int i);
        return (i < gotCyc[l].size()) ? gotCyc[l][i] : -1000;
    endfunction

    function automatic int accCycAt(input int l, input int i);
        return (i < accCyc[l].size()) ? accCyc[l][i] : 1000;
    endfunction

    // Single compare process: every cycle, outputs against the FIFO model.
    always @(negedge clk) begin
        bit blk;
        blk = rst || flush;
        for (int l = 0; l < 3; l++) begin
            if (blk) begin
                checkOutput("blk_in_ready", inReady[l], 0);
                checkOutput("blk_out_valid", outValid[l], 0);
                checkOutput("blk_occupancy", occ[l], rst ? 0 : mq[l].size());
                mq[l].delete();
                stalled[l] = 1'b0;
            end else begin
                checkOutput("occupancy", occ[l], mq[l].size());
                if (mq[l].size() == cap[l]) checkOutput("full_in_ready", inReady[l], 0);
                if (mq[l].size() == 0) begin
                    checkOutput("empty_in_ready", inReady[l], 1);
                    checkOutput("empty_out_valid", outValid[l], 0);
                end
                if (stalled[l]) begin
                    checkOutput("hold_valid", outValid[l], 1);
                    checkOutput("hold_data", outData[l], heldData[l]);
                end
                if (outValid[l] && mq[l].size() > 0) begin
                    checkOutput("order_data", outData[l], mq[l][0]);
                    if (outReady[l]) void'(mq[l].pop_front());
                end
                if (inValid[l] && inReady[l]) mq[l].push_back(inData[l]);
                stalled[l]  = outValid[l] && !outReady[l];
                heldData[l] = outData[l];
            end
        end
        checkOutput("pass_data", d2OutData, d2InData);
        checkOutput("pass_valid", d2OutValid, blk ? 0 : d2InValid);
        checkOutput("pass_ready", d2InReady, blk ? 0 : d2OutReady);
        checkOutput("pass_occupancy", d2Occ, 0);
    end

    task automatic applyStimulus();
        for (int l = 0; l < 3; l++) begin
            inValid[l] = (toSend[l].size() > 0);
            inData[l]  = inValid[l] ? toSend[l][0] : 3'($urandom);
        end
        d2InData   = 6'($urandom);
        d2InValid  = 2'($urandom);
        d2OutReady = 2'($urandom);
        @(negedge clk);
        for (int l = 0; l < 3; l++) begin
            if (inValid[l] && inReady[l]) begin
                void'(toSend[l].pop_front());
                accCyc[l].push_back(cyc);
            end
            if (outValid[l] && outReady[l]) begin
                got[l].push_back(outData[l]);
                gotCyc[l].push_back(cyc);
            end
            if (int'(occ[l]) > maxOcc[l]) maxOcc[l] = occ[l];
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clearLogs();
        for (int l = 0; l < 3; l++) begin
            got[l].delete();
            gotCyc[l].delete();
            accCyc[l].delete();
            maxOcc[l] = 0;
        end
    endtask

    task automatic drainAll();
        bit done;
        done = 1'b0;
        outReady = 3'b111;
        for (int i = 0; i < 60 && !done; i++) begin
            applyStimulus();
            done = (toSend[0].size() == 0) && (toSend[1].size() == 0) && (toSend[2].size() == 0)
                && (occ[0] == 0) && (occ[1] == 0) && (occ[2] == 0) && (outValid == 3'b000);
        end
        if (!done) checkOutput("drain_timeout", 0, 1);
        clearLogs();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        for (int l = 0; l < 3; l++) inData[l] = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_in_ready", inReady, 0);
        checkOutput("reset_out_valid", outValid, 0);
        checkOutput("reset_occupancy", occ[0], 0);
        rst = 1'b0;
        #1;
        checkOutput("post_reset_in_ready", inReady, 3'b111);
        clearLogs();

        // Streaming lane 0.
        outReady = 3'b111;
        for (int v = 0; v < 8; v++) toSend[0].push_back(3'(v));
        repeat (12) applyStimulus();
        checkOutput("stream_count", got[0].size(), 8);
        for (int i = 0; i < 8; i++) checkOutput("stream_value", gotAt(0, i), i);
        checkOutput("stream_latency", gotCycAt(0, 0) - accCycAt(0, 0), 2);
        checkOutput("stream_rate", gotCycAt(0, 7) - gotCycAt(0, 0), 7);
        checkOutput("stream_max_occ", int'(maxOcc[0] <= 2), 1);
        drainAll();

        // Backpressure on lane 1.
        outReady = 3'b101;
        for (int v = 1; v <= 5; v++) toSend[1].push_back(3'(v));
        repeat (6) applyStimulus();
        checkOutput("bp_accepted", accCyc[1].size(), 4);
        checkOutput("bp_in_ready", inReady[1], 0);
        checkOutput("bp_occupancy", occ[1], 4);
        outReady = 3'b111;
        repeat (12) applyStimulus();
        checkOutput("bp_count", got[1].size(), 5);
        for (int i = 0; i < 5; i++) checkOutput("bp_value", gotAt(1, i), i + 1);
        drainAll();

        // Lane 0 stalled full while lane 1 streams.
        outReady = 3'b110;
        for (int v = 7; v >= 3; v--) toSend[0].push_back(3'(v));
        for (int v = 0; v < 8; v++) toSend[1].push_back(3'(v));
        repeat (12) applyStimulus();
        checkOutput("indep_count", got[1].size(), 8);
        for (int i = 0; i < 8; i++) checkOutput("indep_value", gotAt(1, i), i);
        checkOutput("indep_rate", gotCycAt(1, 7) - gotCycAt(1, 0), 7);
        checkOutput("indep_stalled_out", got[0].size(), 0);
        checkOutput("indep_stalled_occ", occ[0], 4);
        outReady = 3'b111;
        repeat (12) applyStimulus();
        for (int i = 0; i < 5; i++) checkOutput("indep_preserved", gotAt(0, i), 7 - i);
        drainAll();

        // Flush with three words held on lane 0.
        outReady = 3'b110;
        toSend[0] = '{3'd1, 3'd2, 3'd3};
        repeat (4) applyStimulus();
        checkOutput("flush_pre_occ", occ[0], 3);
        flush = 1'b1;
        inValid = 3'b111;
        #1;
        checkOutput("flush_in_ready", inReady, 0);
        checkOutput("flush_out_valid", outValid, 0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        #1;
        checkOutput("flush_post_occ", occ[0], 0);
        checkOutput("flush_post_ready", inReady, 3'b111);
        clearLogs();
        outReady = 3'b111;
        toSend[0].push_back(3'd6);
        repeat (6) applyStimulus();
        checkOutput("flush_first_word", gotAt(0, 0), 6);
        checkOutput("flush_word_count", got[0].size(), 1);
        drainAll();

        // Reset for two cycles in the middle of a transfer.
        toSend[0] = '{3'd7, 3'd7, 3'd7, 3'd7};
        applyStimulus();
        rst = 1'b1;
        #1;
        checkOutput("rst_in_ready", inReady, 0);
        checkOutput("rst_out_valid", outValid, 0);
        checkOutput("rst_occupancy", occ[0], 0);
        repeat (2) applyStimulus();
        rst = 1'b0;
        toSend[0].delete();
        clearLogs();
        #1;
        checkOutput("rst_post_ready", inReady, 3'b111);
        toSend[0].push_back(3'd2);
        repeat (5) applyStimulus();
        checkOutput("rst_first_word", gotAt(0, 0), 2);
        checkOutput("rst_latency", gotCycAt(0, 0) - accCycAt(0, 0), 2);
        drainAll();

        // Half-slice lane: one word per two cycles.
        for (int v = 0; v < 8; v++) toSend[2].push_back(3'(v));
        repeat (24) applyStimulus();
        checkOutput("half_count", got[2].size(), 8);
        for (int i = 0; i < 8; i++) checkOutput("half_value", gotAt(2, i), i);
        for (int i = 1; i < 8; i++) checkOutput("half_gap", gotCycAt(2, i) - gotCycAt(2, i - 1), 2);
        checkOutput("half_latency", gotCycAt(2, 0) - accCycAt(2, 0), 3);
        checkOutput("half_max_occ", int'(maxOcc[2] <= 3), 1);
        drainAll();

        // Zero-stage configuration is combinational.
        d2InData   = {3'd2, 3'd5};
        d2InValid  = 2'b01;
        d2OutReady = 2'b10;
        #1;
        checkOutput("pass_lit_data", d2OutData[2:0], 5);
        checkOutput("pass_lit_valid", d2OutValid, 1);
        checkOutput("pass_lit_ready", d2InReady, 2);
        flush = 1'b1;
        #1;
        checkOutput("pass_flush_valid", d2OutValid, 0);
        checkOutput("pass_flush_ready", d2InReady, 0);
        @(posedge clk);
        #1;
        flush = 1'b0;

        // Randomized traffic with occasional flush and reset.
        for (int i = 0; i < 700; i++) begin
            int readyBias;
            readyBias = ((i / 100) % 2 == 0) ? 3 : 1;
            for (int l = 0; l < 3; l++) begin
                inValid[l]  = ($urandom_range(0, 3) != 0);
                inData[l]   = 3'($urandom);
                outReady[l] = ($urandom_range(0, 3) < readyBias);
            end
            d2InData   = 6'($urandom);
            d2InValid  = 2'($urandom);
            d2OutReady = 2'($urandom);
            flush = ($urandom_range(0, 59) == 0);
            rst   = ($urandom_range(0, 199) == 0);
            @(posedge clk);
            #1;
            cyc++;
        end
        flush = 1'b0;
        rst   = 1'b0;
        drainAll();

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nErrors);
        $finish;
    end

endmodule
